// File: rtl/bram_reader_if.sv
// rtl/bram_reader_if.sv - output stream bundle of the BRAM burst reader
interface bram_reader_if #(
    parameter int DATA = 128
);
    logic [DATA-1:0] m_data;
    logic            m_valid;
    logic            m_ready;
    logic            m_last;

    modport master (output m_data, m_valid, m_last, input m_ready);
    modport slave  (input m_data, m_valid, m_last, output m_ready);
endinterface

// File: rtl/bram_reader.sv
// rtl/bram_reader.sv - reads a burst of BRAM words and streams them through a 2-entry FIFO
module bram_reader #(
    parameter int DATA = 128,
    parameter int ADDR = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR-1:0]   base_addr,
    input  logic [ADDR:0]     count,
    output logic              busy,
    output logic              done,
    output logic [ADDR-1:0]   bram_addr,
    input  logic [DATA-1:0]   bram_data,
    bram_reader_if.master     m
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]      state;
    logic [ADDR:0]   remain;
    logic            inflight;
    logic            inflight_last;
    logic [1:0]      occ;
    logic [DATA-1:0] head_data;
    logic [DATA-1:0] tail_data;
    logic            head_last;
    logic            tail_last;
    logic            pop;
    logic            push;
    logic            issue;

    assign pop  = (occ != 2'd0) && m.m_ready;
    assign push = inflight;
    // Only issue when the word it returns is guaranteed a FIFO slot.
    assign issue = (state == S_RUN) && (remain != '0) &&
                   (({1'b0, occ} + {2'b00, inflight}) <= (3'd1 + {2'b00, pop}));

    assign m.m_valid = (occ != 2'd0);
    assign m.m_data  = head_data;
    assign m.m_last  = head_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            bram_addr     <= '0;
            remain        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            occ           <= 2'd0;
            head_data     <= '0;
            tail_data     <= '0;
            head_last     <= 1'b0;
            tail_last     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            state     <= S_RUN;
                            busy      <= 1'b1;
                            bram_addr <= base_addr;
                            remain    <= count;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (pop && head_last) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
            endcase

            if (issue) begin
                bram_addr <= bram_addr + ADDR'(1);
                remain    <= remain - (ADDR+1)'(1);
            end
            inflight      <= issue;
            inflight_last <= issue && (remain == (ADDR+1)'(1));

            // Head register is the stream output; tail catches a word while the head stalls.
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_data <= bram_data;
                        head_last <= inflight_last;
                    end else begin
                        tail_data <= bram_data;
                        tail_last <= inflight_last;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    if (occ == 2'd2) begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                    end
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head_data <= bram_data;
                        head_last <= inflight_last;
                    end else begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                        tail_data <= bram_data;
                        tail_last <= inflight_last;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_reader.sv
// tb/tb_bram_reader.sv - directed and randomized bursts checked against a memory-walk model
module tb_bram_reader;
    localparam int DATA  = 128;
    localparam int ADDR  = 9;
    localparam int DEPTH = 1 << ADDR;

    logic            clk;
    logic            rst;
    logic            start;
    logic [ADDR-1:0] base_addr;
    logic [ADDR:0]   count;
    logic            busy;
    logic            done;
    logic [ADDR-1:0] bram_addr;
    logic [DATA-1:0] bram_data;
    logic [DATA-1:0] mem [DEPTH];

    int n_vec  = 0;
    int n_fail = 0;

    bram_reader_if #(.DATA(DATA)) m_if ();

    bram_reader #(.DATA(DATA), .ADDR(ADDR)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .bram_addr (bram_addr),
        .bram_data (bram_data),
        .m         (m_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) bram_data <= mem[bram_addr];

    task automatic check(input string tag, input logic [DATA-1:0] obs, input logic [DATA-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // mode 0: ready always 1, mode 1: ready pattern 1,0,0,1, mode 2: random ready
    task automatic run_burst(input int base, input int cnt, input int mode, input bit inject);
        int got = 0;
        int first_k = -1;
        int done_k = -1;
        bit prev_stall = 1'b0;
        bit rdy;
        logic [DATA-1:0] prev_d = '0;
        logic prev_l = 1'b0;
        @(negedge clk);
        start     = 1'b1;
        base_addr = ADDR'(base);
        count     = (ADDR+1)'(cnt);
        @(negedge clk);
        start     = 1'b0;
        base_addr = ADDR'($urandom);
        count     = (ADDR+1)'($urandom % (DEPTH + 1));
        if (cnt == 0) begin
            check("zero_done", done, 1);
            check("zero_busy", busy, 0);
            check("zero_valid", m_if.m_valid, 0);
            @(negedge clk);
            check("zero_done_clear", done, 0);
            check("zero_valid_after", m_if.m_valid, 0);
            return;
        end
        check("busy_after_start", busy, 1);
        check("addr_after_start", bram_addr, DATA'(base));
        for (int k = 0; k < 4 * cnt + 20 && done_k < 0; k++) begin
            if (k > 0) @(negedge clk);
            if (inject) begin
                start     = (k == 3);
                base_addr = ADDR'($urandom);
                count     = (ADDR+1)'(1 + $urandom % 40);
            end
            if (prev_stall) begin
                check("hold_valid", m_if.m_valid, 1);
                check("hold_data", m_if.m_data, prev_d);
                check("hold_last", m_if.m_last, prev_l);
            end
            check("occ_max", dut.occ <= 2'd2, 1);
            if (m_if.m_valid && first_k < 0) first_k = k;
            if (done) begin
                done_k = k;
                check("busy_at_done", busy, 0);
                check("beats_at_done", got, cnt);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (k % 4 == 0) || (k % 4 == 3);
                default: rdy = $urandom % 2;
            endcase
            m_if.m_ready = rdy;
            if (m_if.m_valid && rdy) begin
                check("beat_data", m_if.m_data, mem[(base + got) % DEPTH]);
                check("beat_last", m_if.m_last, (got == cnt - 1));
                got++;
            end
            prev_stall = m_if.m_valid && !rdy;
            prev_d     = m_if.m_data;
            prev_l     = m_if.m_last;
        end
        start = 1'b0;
        check("done_seen", done_k >= 0, 1);
        check("beat_total", got, cnt);
        if (mode == 0) begin
            check("first_valid_latency", first_k, 2);
            check("done_latency", done_k, cnt + 2);
        end
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("valid_after_done", m_if.m_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        rst          = 1'b1;
        start        = 1'b0;
        base_addr    = '0;
        count        = '0;
        m_if.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", m_if.m_valid, 0);
        check("rst_last", m_if.m_last, 0);
        check("rst_addr", bram_addr, 0);
        check("rst_data", m_if.m_data, 0);
        rst = 1'b0;

        run_burst(9'h010, 4, 0, 1'b0);
        run_burst(9'h1FE, 4, 0, 1'b0);
        run_burst(int'($urandom % DEPTH), 8, 1, 1'b0);
        run_burst(9'h055, 0, 0, 1'b0);
        run_burst(9'h0C3, 1, 0, 1'b0);
        run_burst(int'($urandom % DEPTH), DEPTH, 2, 1'b0);

        // Reset lands just after the third beat of a 16-word burst.
        @(negedge clk);
        start        = 1'b1;
        base_addr    = 9'h0A0;
        count        = 10'd16;
        m_if.m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_beat3", m_if.m_data, mem[9'h0A2]);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_valid", m_if.m_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_addr", bram_addr, 0);
        check("midrst_data", m_if.m_data, 0);
        run_burst(9'h020, 2, 0, 1'b0);

        run_burst(9'h040, 10, 0, 1'b1);
        run_burst(9'h1F0, 12, 1, 1'b1);
        for (int i = 0; i < 4; i++)
            run_burst(int'($urandom % DEPTH), int'(1 + $urandom % 20), 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
